fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
Program-counter and fetch-control stage of the Yu single-cycle core. It sits directly upstream of the instruction ROM and drives the ROM address every cycle. It selects the next PC from sequential, branch and jump sources, and supports stall and halt/resume control. Redirect targets that are not word-aligned are trapped.

Parameters:
ADDR_WIDTH, 32, PC / ROM address width in bits.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
PC_STEP, 4, byte increment for sequential fetch.

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hold PC (hazard or memory wait)
branch_taken  input  1  conditional branch resolved taken this cycle
branch_target  input  ADDR_WIDTH  branch destination
jump  input  1  unconditional jump (JAL/JALR) this cycle
jump_target  input  ADDR_WIDTH  jump destination
halt_req  input  1  request to stop fetching
resume  input  1  leave HALTED or TRAP state
pc  output  ADDR_WIDTH  current PC; drives instruction ROM addr
pc_plus4  output  ADDR_WIDTH  pc + PC_STEP, for link-register writeback
fetch_valid  output  1  instruction at pc is to be executed this cycle
misaligned  output  1  sticky; set when a redirect target has addr[1:0] != 0
state  output  2  FSM state, for debug

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: pc = RESET_VECTOR, state = BOOT, fetch_valid = 0, misaligned = 0. Reset has priority over every other input, including reset asserted mid-stall, mid-halt or in TRAP.
- FSM encodings:
  - BOOT = 2'd0: exactly one cycle after reset, PC held, fetch_valid = 0. Next state is RUN unconditionally.
  - RUN = 2'd1: fetch_valid = 1 unless stall = 1.
  - HALTED = 2'd2: PC frozen, fetch_valid = 0.
  - TRAP = 2'd3: PC frozen at the offending instruction, fetch_valid = 0.
- Next-PC priority in RUN with stall = 0: jump > branch_taken > sequential.
  - Sequential: pc + PC_STEP, modulo 2^ADDR_WIDTH. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Stall: stall = 1 in RUN holds pc, and jump, branch_taken and halt_req are ignored that cycle. The upstream logic must re-present them.
- Halt: halt_req = 1 in RUN with stall = 0:
  - The current instruction completes and the PC still advances by the priority rule.
  - State goes to HALTED next cycle.
  - If jump or branch_taken is asserted in the same cycle, the redirect is applied before halting.
- Misaligned redirect: a selected jump_target or branch_target with addr[1:0] != 0:
  - pc is not updated; misaligned is set to 1; state goes to TRAP.
  - An unselected misaligned target (e.g. a misaligned branch_target while jump = 1 wins) has no effect.
- Resume:
  - In HALTED: resume = 1 gives RUN next cycle with pc unchanged.
  - In TRAP: resume = 1 clears misaligned, advances pc by PC_STEP (skipping the faulting instruction), then RUN.
  - resume is ignored in BOOT and RUN.
- Always-valid outputs: pc_plus4 is combinational from pc in every state. pc is registered, so ROM data for the new pc appears in the same cycle as the new pc.
- Latency: a redirect asserted in cycle N appears on pc in cycle N+1.

Decomposition:
- Parameters.vh holds the FSM state localparams (FETCH_BOOT, FETCH_RUN, FETCH_HALTED, FETCH_TRAP), PC_STEP and RESET_VECTOR, alongside the existing ADDR_WIDTH_32 and DATA_WIDTH_32.
- One combinational sub-module, next_pc_sel, is natural. It contains the priority mux, the adder and the alignment check, and outputs next_pc and target_misaligned. The FSM and PC register stay in fetch_pc_unit.

Test Plan:
1. Reset then free run:
   - Stimulus: rst high 2 cycles, then low.
   - Response: pc = 0 during BOOT with fetch_valid = 0; then pc = 0, 4, 8, 12 with fetch_valid = 1.
2. Redirect priority:
   - Stimulus: at pc = 8, jump = 1 with jump_target = 0x100, and branch_taken = 1 with branch_target = 0x200.
   - Response: next pc = 0x100. A following lone branch_taken to 0x40 gives pc = 0x40.
3. Stall interaction:
   - Stimulus: at pc = 0x20, stall = 1 for 3 cycles with jump = 1 (target 0x80) in the first stall cycle.
   - Response: pc stays 0x20 and fetch_valid = 0 for those 3 cycles; the jump is dropped; then pc = 0x24.
4. Misaligned trap and recovery:
   - Stimulus: at pc = 0x30, branch_taken = 1 with branch_target = 0x42.
   - Response: state = TRAP, misaligned = 1, pc = 0x30.
   - Then resume = 1: misaligned = 0, pc = 0x34, state = RUN.
5. Halt, resume, and wrap:
   - Stimulus: halt_req at pc = 0x10.
   - Response: pc = 0x14 and HALTED, frozen for 5 cycles; resume gives RUN at 0x14.
   - Separately, a jump to 0xFFFF_FFFC followed by a sequential step gives pc = 0x0.
6. Reset mid-operation:
   - Stimulus: assert rst while in TRAP with pc = 0x30.
   - Response: next cycle pc = RESET_VECTOR, state = BOOT, misaligned = 0.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch/PC stage: FSM encodings, reset vector,
// sequential step and core-wide widths.
package fetch_pc_unit_pkg;

  localparam int ADDR_WIDTH_32 = 32;
  localparam int DATA_WIDTH_32 = 32;

  localparam int          PC_STEP      = 4;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_BOOT   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALTED = 2'd2,
    FETCH_TRAP   = 2'd3
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Next-PC selection: jump > branch > sequential, plus the alignment check
// on whichever redirect target is actually selected.
module next_pc_sel #(
  parameter int ADDR_WIDTH = 32,
  parameter int PC_STEP    = 4
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] seq_pc,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  target_misaligned
);
  import fetch_pc_unit_pkg::*;

  // Sequential step wraps modulo 2^ADDR_WIDTH by plain truncation.
  assign seq_pc = pc + ADDR_WIDTH'(PC_STEP);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else leaves it unassigned and a latch is inferred.
  always_comb begin
    next_pc           = seq_pc;
    target_misaligned = 1'b0;
    if (jump) begin
      next_pc           = jump_target;
      target_misaligned = !is_word_aligned(jump_target[1:0]);
    end else if (branch_taken) begin
      next_pc           = branch_target;
      target_misaligned = !is_word_aligned(branch_target[1:0]);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and fetch-control FSM (BOOT/RUN/HALTED/TRAP) driving the
// instruction ROM address every cycle.
module fetch_pc_unit #(
  parameter int                   ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(fetch_pc_unit_pkg::RESET_VECTOR),
  parameter int                   PC_STEP      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  fetch_valid,
  output logic                  misaligned,
  output logic [1:0]            state
);
  import fetch_pc_unit_pkg::*;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  mis_q, mis_d;
  logic [ADDR_WIDTH-1:0] sel_pc;
  logic                  target_misaligned;

  next_pc_sel #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PC_STEP    (PC_STEP)
  ) u_next_pc_sel (
    .pc                (pc_q),
    .jump              (jump),
    .jump_target       (jump_target),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .seq_pc            (pc_plus4),
    .next_pc           (sel_pc),
    .target_misaligned (target_misaligned)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mis_d       = mis_q;
    fetch_valid = 1'b0;
    unique case (state_q)
      FETCH_BOOT: state_d = FETCH_RUN;
      FETCH_RUN: begin
        fetch_valid = !stall;
        // A stalled cycle drops every redirect and halt; upstream re-presents them.
        if (!stall) begin
          if (target_misaligned) begin
            mis_d   = 1'b1;
            state_d = FETCH_TRAP;
          end else begin
            pc_d = sel_pc;
            if (halt_req) state_d = FETCH_HALTED;
          end
        end
      end
      FETCH_HALTED: if (resume) state_d = FETCH_RUN;
      FETCH_TRAP: begin
        // Recovery skips the faulting instruction.
        if (resume) begin
          mis_d   = 1'b0;
          pc_d    = pc_plus4;
          state_d = FETCH_RUN;
        end
      end
      default: state_d = FETCH_BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  assign pc         = pc_q;
  assign misaligned = mis_q;
  assign state      = state_q;

endmodule
